imem_loader: RTL

Boot-time instruction memory for the Y86-64 pipeline. It accepts a length-prefixed program byte stream over a valid/ready handshake and writes it into an internal byte array. It then releases the processor by asserting `cpu_run` and serves the fetch stage's 10-byte instruction window at the fetch PC. It sits directly upstream of fetch and replaces the free-standing `insmem` array in the processor top level.

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time Y86-64 instruction memory.
// Accepts a length-prefixed byte stream (LEN_LO, LEN_HI, payload[, CKSUM])
// over valid/ready, stores it in a byte array, then releases the core via
// cpu_run and serves a combinational 10-byte fetch window at F_PC.
// Optional feature macro: IMEM_CKSUM_EN -- when defined, a trailing XOR
// checksum byte is required and checked before the core is released.
module imem_loader #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        load_req,
  input  logic [63:0] F_PC,
  output logic [79:0] f_bytes,
  output logic        imem_er,
  output logic        cpu_run,
  output logic        load_err,
  output logic [15:0] byte_count
);

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    LOAD  = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Largest legal LEN, and the last PC whose 10-byte window fits in memory.
  localparam logic [16:0] LEN_MAX = 17'(DEPTH);
  localparam logic [63:0] PC_MAX  = 64'(DEPTH - 10);

  state_t      state, state_nx;
  logic [15:0] len_q;
  logic [15:0] count_q;
`ifdef IMEM_CKSUM_EN
  logic [7:0]  cksum_q;
`endif
  logic [7:0]  mem [DEPTH];

  logic        xfer;
  logic        restart;
  logic        mem_we;
  logic [15:0] hdr_len;
  logic [15:0] count_inc;
  logic [AW-1:0] fetch_base;

  assign xfer      = in_valid && in_ready;
  assign restart   = load_req && ((state == DONE) || (state == ERR));
  assign hdr_len   = {in_data, len_q[7:0]};
  assign count_inc = count_q + 16'd1;

  // FSM state register.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR0;
    else        state <= state_nx;
  end

  // Next-state decode and memory write strobe.
  // NOTE: every output of this block gets a default first, otherwise a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    unique case (state)
      HDR0: if (xfer) state_nx = HDR1;
      HDR1: begin
        if (xfer) begin
          if ({1'b0, hdr_len} > LEN_MAX) state_nx = ERR;
`ifdef IMEM_CKSUM_EN
          else if (hdr_len == 16'd0)     state_nx = CKSUM;
`else
          else if (hdr_len == 16'd0)     state_nx = DONE;
`endif
          else                           state_nx = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          mem_we = 1'b1;
`ifdef IMEM_CKSUM_EN
          if (count_inc == len_q) state_nx = CKSUM;
`else
          if (count_inc == len_q) state_nx = DONE;
`endif
        end
      end
`ifdef IMEM_CKSUM_EN
      CKSUM: if (xfer) state_nx = (in_data == cksum_q) ? DONE : ERR;
`endif
      DONE: if (load_req) state_nx = HDR0;
      ERR:  if (load_req) state_nx = HDR0;
      default: state_nx = HDR0;
    endcase
  end

  // Header length capture, payload counter and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      count_q <= '0;
`ifdef IMEM_CKSUM_EN
      cksum_q <= '0;
`endif
    end else if (restart) begin
      count_q <= '0;
`ifdef IMEM_CKSUM_EN
      cksum_q <= '0;
`endif
    end else if (xfer) begin
      case (state)
        HDR0: len_q[7:0]  <= in_data;
        HDR1: len_q[15:8] <= in_data;
        LOAD: begin
          count_q <= count_inc;
`ifdef IMEM_CKSUM_EN
          cksum_q <= cksum_q ^ in_data;
`endif
        end
        default: ;
      endcase
    end
  end

  // Payload byte array write port.
  // NOTE: the array has no reset -- contents deliberately survive both
  // rst_n and load_req, and a reset would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[AW-1:0]] <= in_data;
  end

  assign in_ready   = (state == HDR0) || (state == HDR1) ||
                      (state == LOAD) || (state == CKSUM);
  assign cpu_run    = (state == DONE);
  assign load_err   = (state == ERR);
  assign byte_count = count_q;
  assign fetch_base = F_PC[AW-1:0];

  // Combinational 10-byte fetch window, zeroed on an address error.
  always_comb begin
    imem_er = !cpu_run || (F_PC > PC_MAX);
    f_bytes = '0;
    if (!imem_er) begin
      for (int i = 0; i < 10; i++) begin
        f_bytes[8*i +: 8] = mem[fetch_base + AW'(i)];
      end
    end
  end

endmodule
